// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, addresses an
// asynchronous-read program ROM, registers the returned word and hands it
// to decode over a valid/ready handshake. Start/halt control and branch
// redirects steer the PC.
module fetch_unit #(
  parameter int          ADDR_W   = 3,
  parameter int          DATA_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_halt_req,
  input  logic              i_branch_en,
  input  logic [ADDR_W-1:0] i_branch_target,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_inst_out,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  output logic              o_running
);

  localparam logic [ADDR_W-1:0] LP_RESET_PC = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_inst_out;
  logic [ADDR_W-1:0]   r_inst_pc;
  logic                r_inst_valid;
  logic                r_running;

  logic                w_in_run;
  logic                w_accept;
  logic                w_branch;
  logic                w_restart;
  logic                w_fetch;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: start always lands in RUN and beats halt_req
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (i_start)         w_next_state = S_RUN;
        else if (i_halt_req) w_next_state = S_HALT;
      end
      S_HALT: begin
        if (i_start) w_next_state = S_RUN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Control decode: a branch in RUN outranks start; fetch only when nothing
  // else claims the cycle and the output slot is free or draining
  always_comb begin
    w_in_run  = (r_state == S_RUN);
    w_accept  = r_inst_valid & i_inst_ready;
    w_branch  = w_in_run & i_branch_en;
    w_restart = i_start & ~w_branch;
    w_fetch   = w_in_run & ~i_branch_en & ~i_start & ~i_halt_req &
                (~r_inst_valid | i_inst_ready);
  end

  // Program counter: branch target, restart vector or sequential increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= LP_RESET_PC;
    end else if (w_branch) begin
      r_pc <= i_branch_target;
    end else if (w_restart) begin
      r_pc <= LP_RESET_PC;
    end else if (w_fetch) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  // Output slot: flushed by branch/restart, filled on fetch, emptied on accept
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inst_valid <= 1'b0;
      r_inst_out   <= '0;
      r_inst_pc    <= '0;
    end else begin
      if (w_branch || w_restart) begin
        r_inst_valid <= 1'b0;
      end else if (w_fetch) begin
        r_inst_valid <= 1'b1;
      end else if (w_accept) begin
        r_inst_valid <= 1'b0;
      end
      if (w_fetch) begin
        r_inst_out <= i_rom_data;
        r_inst_pc  <= r_pc;
      end
    end
  end

  // Running flag registered alongside the state transition
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_running <= 1'b0;
    end else begin
      r_running <= (w_next_state == S_RUN);
    end
  end

  assign o_rom_addr   = r_pc;
  assign o_inst_out   = r_inst_out;
  assign o_inst_pc    = r_inst_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_running    = r_running;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table for the
// streaming, stall and branch behaviour, hand-written sequences for halt,
// mid-stream reset and start/halt collision, and a scoreboard that checks
// every accepted word in order.
module tb_fetch_unit;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rstN;
  logic          start;
  logic          haltReq;
  logic          branchEn;
  logic [AW-1:0] branchTarget;
  logic [AW-1:0] romAddr;
  logic [DW-1:0] romData;
  logic [DW-1:0] instOut;
  logic [AW-1:0] instPc;
  logic          instValid;
  logic          instReady;
  logic          running;

  typedef struct {
    logic          start;
    logic          halt;
    logic          brEn;
    logic [AW-1:0] brTgt;
    logic          ready;
    logic          expValid;
    logic [AW-1:0] expPc;
    logic [AW-1:0] expAddr;
    logic          expRun;
    logic          fresh;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_start        (start),
    .i_halt_req     (haltReq),
    .i_branch_en    (branchEn),
    .i_branch_target(branchTarget),
    .o_rom_addr     (romAddr),
    .i_rom_data     (romData),
    .o_inst_out     (instOut),
    .o_inst_pc      (instPc),
    .o_inst_valid   (instValid),
    .i_inst_ready   (instReady),
    .o_running      (running)
  );

  // Program ROM contents: a recognisable word derived from the address
  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
    return 16'h5A00 + 16'(a) + 16'd1;
  endfunction

  assign romData = romWord(romAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int s, input int h, input int b, input int t,
                              input int r, input int v, input int pc,
                              input int addr, input int run, input int fr);
    vec_t x;
    x.start = 1'(s); x.halt = 1'(h); x.brEn = 1'(b); x.brTgt = AW'(t);
    x.ready = 1'(r); x.expValid = 1'(v); x.expPc = AW'(pc % 8);
    x.expAddr = AW'(addr % 8); x.expRun = 1'(run); x.fresh = 1'(fr);
    return x;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic b,
                               input logic [AW-1:0] t, input logic r);
    start = s; haltReq = h; branchEn = b; branchTarget = t; instReady = r;
  endtask

  // One clock: record any handshake completing on this edge and score it
  task automatic tick();
    logic          hs;
    logic [AW-1:0] capPc;
    logic [DW-1:0] capOut;
    sb_t           e;
    hs     = instValid & instReady & rstN;
    capPc  = instPc;
    capOut = instOut;
    @(posedge clk);
    #1;
    if (hs && rstN) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_pc", int'(capPc), int'(e.pc));
        checkOutput("sb_word", int'(capOut), int'(e.word));
      end
    end
  endtask

  task automatic expectWord(input int pc);
    sb_t e;
    e.pc = AW'(pc % 8);
    e.word = romWord(e.pc);
    sbQ.push_back(e);
  endtask

  task automatic checkState(input string name, input int v, input int addr, input int run);
    checkOutput({name, "_valid"}, int'(instValid), v);
    checkOutput({name, "_addr"}, int'(romAddr), addr);
    checkOutput({name, "_running"}, int'(running), run);
  endtask

  task automatic checkWord(input string name, input int pc);
    checkOutput({name, "_pc"}, int'(instPc), pc);
    checkOutput({name, "_out"}, int'(instOut), int'(romWord(AW'(pc))));
  endtask

  initial begin
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    #1 rstN = 1'b0;
    #1;
    checkState("reset", 0, 0, 0);
    checkOutput("reset_inst_out", int'(instOut), 0);
    checkOutput("reset_inst_pc", int'(instPc), 0);
    tick();
    tick();
    rstN = 1'b1;
    tick();
    checkState("idle", 0, 0, 0);

    // Streaming with wrap, 3-cycle stall at pc 2, then a branch to 5
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    for (int k = 0; k <= 10; k++) vecs.push_back(mk(0, 0, 0, 0, 1, 1, k, k + 1, 1, 1));
    for (int k = 0; k < 3; k++)   vecs.push_back(mk(0, 0, 0, 0, 0, 1, 2, 3, 1, 0));
    for (int k = 3; k <= 9; k++)  vecs.push_back(mk(0, 0, 0, 0, 1, 1, k, k + 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 5, 1, 0, 0, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5, 6, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 6, 7, 1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].halt, vecs[i].brEn, vecs[i].brTgt, vecs[i].ready);
      tick();
      checkState($sformatf("vec%0d", i), int'(vecs[i].expValid),
                 int'(vecs[i].expAddr), int'(vecs[i].expRun));
      if (vecs[i].expValid) checkWord($sformatf("vec%0d", i), int'(vecs[i].expPc));
      if (vecs[i].fresh) expectWord(int'(vecs[i].expPc));
    end

    // Halt while the held word is not yet accepted
    applyStimulus(0, 1, 0, 0, 0);
    tick();
    checkState("halt_enter", 1, 7, 0);
    checkWord("halt_enter", 6);
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkState("halt_hold", 1, 7, 0);
    checkWord("halt_hold", 6);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkState("halt_drain", 0, 7, 0);
    applyStimulus(0, 0, 1, 3, 1);
    tick();
    checkState("halt_branch_ignored", 0, 7, 0);
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    checkState("halt_restart", 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    for (int k = 0; k <= 4; k++) begin
      tick();
      checkState($sformatf("resume%0d", k), 1, k + 1, 1);
      checkWord($sformatf("resume%0d", k), k);
      expectWord(k);
    end

    // Asynchronous reset mid-stream while pc 4 is valid
    applyStimulus(0, 0, 0, 0, 0);
    #2 rstN = 1'b0;
    #1;
    checkState("async_reset", 0, 0, 0);
    checkOutput("async_reset_out", int'(instOut), 0);
    checkOutput("async_reset_pc", int'(instPc), 0);
    sbQ.delete();
    tick();
    rstN = 1'b1;
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    tick();
    checkState("post_reset_idle", 0, 0, 0);

    // start and halt_req together from HALT
    applyStimulus(1, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    expectWord(0);
    applyStimulus(0, 1, 0, 0, 1);
    tick();
    checkState("halt_again", 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 1);
    tick();
    checkState("start_beats_halt", 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    tick();
    checkState("collide_fetch0", 1, 1, 1);
    checkWord("collide_fetch0", 0);
    expectWord(0);
    tick();
    checkWord("collide_fetch1", 1);
    expectWord(1);
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkOutput("sb_pending", sbQ.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
